// File: rtl/ahb_mgr.sv
// AHB-Lite manager: turns valid/ready commands into pipelined NONSEQ SINGLE
// transfers, with ERROR-response cancellation and a hung-subordinate timeout.
module ahb_mgr #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              fault,
  input  logic              clr_fault,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [1:0]        hsize,
  output logic [2:0]        hburst,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready;
  // rsp_valid is a single-cycle pulse with no back-pressure.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              a_valid_q, a_valid_d;
  logic              a_write_q, a_write_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [1:0]        a_size_q, a_size_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_to_q, rsp_to_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              cancel;
  logic              run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      a_valid_q   <= 1'b0;
      a_write_q   <= 1'b0;
      a_addr_q    <= '0;
      a_size_q    <= '0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      a_valid_q   <= a_valid_d;
      a_write_q   <= a_write_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_valid_d   = a_valid_q;
    a_write_d   = a_write_q;
    a_addr_d    = a_addr_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    rsp_rdata_d = '0;
    // An ERROR in the data phase suppresses the pending address phase.
    cancel      = d_valid_q & hresp;
    run         = (state_q == ST_RUN);
    cmd_ready   = run & hready & ~cancel;
    htrans      = (run & a_valid_q & ~cancel) ? 2'b10 : 2'b00;

    unique case (state_q)
      ST_RUN: begin
        if (d_valid_q & hready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = hresp;
          rsp_rdata_d = d_write_q ? '0 : hrdata;
        end
        if (d_valid_q & ~hready) begin
          if (cnt_q == CNT_LAST) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b1;
            d_valid_d   = 1'b0;
            cnt_d       = '0;
            fault_d     = 1'b1;
            state_d     = ST_FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
        if (hready & ~cancel) begin
          d_valid_d = a_valid_q;
          d_write_d = a_write_q;
          d_wdata_d = a_wdata_q;
          if (cmd_valid) begin
            a_valid_d = 1'b1;
            a_write_d = cmd_write;
            a_addr_d  = cmd_addr;
            a_size_d  = cmd_size;
            a_wdata_d = cmd_wdata;
          end else begin
            a_valid_d = 1'b0;
          end
        end else if (hready & cancel) begin
          d_valid_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (a_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end
        a_valid_d = 1'b0;
        state_d   = ST_HALT;
      end
      ST_HALT: begin
        if (clr_fault) begin
          state_d = ST_RUN;
          fault_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign hsel        = (htrans == 2'b10);
  assign haddr       = a_addr_q;
  assign hsize       = a_size_q;
  assign hburst      = 3'b000;
  assign hwrite      = a_write_q;
  assign hwdata      = d_wdata_q;
  assign busy        = a_valid_q | d_valid_q;
  assign fault       = fault_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ahb_mgr.sv
// Bench for ahb_mgr: a transaction-level bus/response model checks every
// cycle; directed sequences pin exact cycle-level expectations.
module tb_ahb_mgr;
  localparam int TIMEOUT = 8;

  typedef struct packed { logic w; logic [9:0] a; logic [1:0] s; logic [63:0] d; } cmd_t;
  typedef struct packed { logic [31:0] due; logic err; logic to; logic [63:0] rd; } rsp_t;
  typedef struct packed {
    logic acc; logic [1:0] ht; logic [9:0] ad; logic wr; logic [63:0] wd;
    logic rv; logic re; logic rt; logic [63:0] rd; logic flt; logic cr;
  } tr_t;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [1:0] cmd_size = '0;
  logic [63:0] cmd_wdata = '0;
  logic rsp_valid, rsp_err, rsp_timeout, busy, fault, clr_fault = 1'b0;
  logic [63:0] rsp_rdata, hwdata, hrdata = '0;
  logic hsel, hwrite, hready = 1'b1, hresp = 1'b0;
  logic [9:0] haddr;
  logic [1:0] htrans, hsize, dbg_state;
  logic [2:0] hburst;

  ahb_mgr #(.TIMEOUT(TIMEOUT), .ADDR_W(10), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .fault(fault), .clr_fault(clr_fault), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk = ~clk;
  int unsigned cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // ---------------- model state ----------------
  int n_tests = 0, n_fail = 0;
  cmd_t issue_q[$];
  rsp_t exp_q[$];
  tr_t tr[$];
  cmd_t dcmd;
  logic dv = 1'b0, m_fault = 1'b0, m_flush = 1'b0, trace_on = 1'b0, rand_sub = 1'b0;
  int m_cnt = 0, dph_cyc = 0, d_wait = 0;
  logic d_err = 1'b0, rd_fixed_en = 1'b0;
  logic [63:0] rd_fixed = '0;
  int pw_q[$];
  logic pe_q[$];
  logic [9:0] regmap [8];

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic rsp_t mk_rsp(logic [31:0] due, logic e, logic t, logic [63:0] rd);
    return {due, e, t, rd};
  endfunction

  task automatic choose_plan();
    int r;
    if (pw_q.size() > 0) begin
      d_wait = pw_q.pop_front();
      d_err  = pe_q.pop_front();
    end else if (rand_sub) begin
      r = $urandom_range(0, 99);
      d_wait = (r < 2) ? 1000 : (r < 30) ? $urandom_range(1, 3) : 0;
      d_err  = ($urandom_range(0, 7) == 0);
    end else begin
      d_wait = 0;
      d_err  = 1'b0;
    end
  endtask

  // ---------------- subordinate driver ----------------
  initial forever begin
    @(posedge clk); #1;
    if (rst || !dv) begin
      hready = 1'b1; hresp = 1'b0;
    end else if (dph_cyc < d_wait) begin
      hready = 1'b0; hresp = 1'b0;
    end else if (d_err) begin
      hresp = 1'b1; hready = (dph_cyc == d_wait + 1);
    end else begin
      hready = 1'b1; hresp = 1'b0;
    end
    hrdata = rd_fixed_en ? rd_fixed : {$urandom, $urandom};
  end

  // ---------------- monitor / scoreboard ----------------
  logic cancel_m, f0, fl0;
  logic [1:0] exp_ht;
  rsp_t r_pop;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      cancel_m = dv && hresp;
      exp_ht = (issue_q.size() > 0 && !m_fault && !cancel_m) ? 2'b10 : 2'b00;
      if (trace_on)
        tr.push_back({cmd_valid && cmd_ready, htrans, haddr, hwrite, hwdata, rsp_valid,
                      rsp_err, rsp_timeout, rsp_rdata, fault, cmd_ready});
      chk("htrans", 80'(htrans), 80'(exp_ht));
      chk("hsel_hburst", 80'({hsel, hburst}), 80'({exp_ht == 2'b10, 3'b000}));
      if (exp_ht == 2'b10)
        chk("addr_phase", 80'({haddr, hwrite, hsize}), 80'({issue_q[0].a, issue_q[0].w, issue_q[0].s}));
      if (dv && dcmd.w) chk("hwdata", 80'(hwdata), 80'(dcmd.d));
      chk("cmd_ready", 80'(cmd_ready), 80'(!m_fault && hready && !cancel_m));
      chk("busy", 80'(busy), 80'(issue_q.size() > 0 || dv));
      chk("fault", 80'(fault), 80'(m_fault));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r_pop = exp_q.pop_front();
        chk("rsp", 80'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 80'({1'b1, r_pop.err, r_pop.to, r_pop.rd}));
      end else begin
        chk("rsp_idle", 80'(rsp_valid), 80'(0));
      end
      // consequences of the coming edge
      f0 = m_fault; fl0 = m_flush;
      if (fl0) begin
        issue_q.delete();
        m_flush = 1'b0;
      end else if (f0) begin
        if (clr_fault) m_fault = 1'b0;
      end else begin
        if (dv) begin
          if (hready) begin
            exp_q.push_back(mk_rsp(cyc + 1, hresp, 1'b0, dcmd.w ? 64'd0 : hrdata));
            dv = 1'b0; m_cnt = 0;
          end else begin
            m_cnt++; dph_cyc++;
            if (m_cnt == TIMEOUT) begin
              exp_q.push_back(mk_rsp(cyc + 1, 1'b1, 1'b1, 64'd0));
              if (issue_q.size() > 0) exp_q.push_back(mk_rsp(cyc + 2, 1'b1, 1'b1, 64'd0));
              dv = 1'b0; m_cnt = 0; m_fault = 1'b1; m_flush = 1'b1;
            end
          end
        end else begin
          m_cnt = 0;
        end
        if (exp_ht == 2'b10 && hready) begin
          dcmd = issue_q.pop_front();
          dv = 1'b1; dph_cyc = 0;
          choose_plan();
        end
        if (cmd_valid && cmd_ready) issue_q.push_back({cmd_write, cmd_addr, cmd_size, cmd_wdata});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic align(); @(posedge clk); #1; endtask
  task automatic wait_cycles(input int n); repeat (n) @(posedge clk); #1; endtask

  task automatic issue(input logic w, input logic [9:0] a, input logic [1:0] s, input logic [63:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 100) begin chk("issue_accept_bound", 80'(0), 80'(1)); break; end
    end
    align();
  endtask

  task automatic start_trace(); tr.delete(); trace_on = 1'b1; endtask

  function automatic int acc_idx(int k);
    int n = 0;
    foreach (tr[i]) if (tr[i].acc) begin
      if (n == k) return i;
      n++;
    end
    return -1000;
  endfunction

  task automatic reset_outputs_chk(input string pfx);
    chk({pfx, "_bus"}, 80'({htrans, hsel, haddr, hwrite, hsize, hburst, busy, fault}), 80'(0));
    chk({pfx, "_hwdata"}, 80'(hwdata), 80'(0));
    chk({pfx, "_rsp"}, 80'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 80'(0));
  endtask

  task automatic clear_model();
    issue_q.delete(); exp_q.delete(); pw_q.delete(); pe_q.delete();
    dv = 1'b0; m_fault = 1'b0; m_flush = 1'b0; m_cnt = 0; dph_cyc = 0;
  endtask

  // ---------------- main sequence ----------------
  logic last_acc;
  int a, c, n_rv;
  initial begin
    regmap[0] = 10'h000; regmap[1] = 10'h008; regmap[2] = 10'h010; regmap[3] = 10'h018;
    regmap[4] = 10'h020; regmap[5] = 10'h022; regmap[6] = 10'h023; regmap[7] = 10'h024;
    repeat (3) @(posedge clk);
    #1 reset_outputs_chk("reset");
    #1 rst = 1'b0;
    align();

    // single zero-wait write
    start_trace();
    issue(1'b1, 10'h010, 2'b11, 64'h1122334455667788);
    cmd_valid = 1'b0;
    wait_cycles(6);
    a = acc_idx(0);
    chk("t1_addr_phase", 80'({tr[a+1].ht, tr[a+1].ad, tr[a+1].wr}), 80'({2'b10, 10'h010, 1'b1}));
    chk("t1_hwdata", 80'(tr[a+2].wd), 80'(64'h1122334455667788));
    chk("t1_no_early_rsp", 80'(tr[a+2].rv), 80'(0));
    chk("t1_rsp", 80'({tr[a+3].rv, tr[a+3].re}), 80'({1'b1, 1'b0}));

    // four back-to-back writes
    start_trace();
    for (int k = 1; k <= 4; k++) issue(1'b1, 10'h000, 2'b11, 64'(k));
    cmd_valid = 1'b0;
    wait_cycles(10);
    a = acc_idx(0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_accept", 80'(tr[a+i].acc), 80'(1));
      chk("t2_nonseq", 80'(tr[a+1+i].ht), 80'(2'b10));
      chk("t2_hwdata", 80'(tr[a+2+i].wd), 80'(i + 1));
      chk("t2_rsp", 80'(tr[a+3+i].rv), 80'(1));
    end

    // read with two wait states and a queued write behind it
    start_trace();
    pw_q.push_back(2); pe_q.push_back(1'b0);
    pw_q.push_back(0); pe_q.push_back(1'b0);
    rd_fixed_en = 1'b1; rd_fixed = 64'hDEADBEEFCAFEF00D;
    issue(1'b0, 10'h018, 2'b11, 64'd0);
    issue(1'b1, 10'h000, 2'b11, 64'h55);
    cmd_valid = 1'b0;
    wait_cycles(10);
    rd_fixed_en = 1'b0;
    a = acc_idx(0);
    chk("t3_second_accept", 80'(acc_idx(1)), 80'(a + 1));
    for (int i = 2; i <= 4; i++)
      chk("t3_stable", 80'({tr[a+i].ht, tr[a+i].ad}), 80'({2'b10, 10'h000}));
    chk("t3_wait_no_rsp", 80'({tr[a+3].rv, tr[a+4].rv}), 80'(0));
    chk("t3_rdata", 80'({tr[a+5].rv, tr[a+5].re, tr[a+5].rd}), 80'({1'b1, 1'b0, 64'hDEADBEEFCAFEF00D}));

    // ERROR on a write, queued read re-issued afterwards
    start_trace();
    pw_q.push_back(0); pe_q.push_back(1'b1);
    pw_q.push_back(0); pe_q.push_back(1'b0);
    issue(1'b1, 10'h030, 2'b11, 64'h1234);
    issue(1'b0, 10'h023, 2'b00, 64'd0);
    cmd_valid = 1'b0;
    wait_cycles(10);
    a = acc_idx(0);
    chk("t4_idle_err1", 80'(tr[a+2].ht), 80'(2'b00));
    chk("t4_idle_err2", 80'(tr[a+3].ht), 80'(2'b00));
    chk("t4_wr_err", 80'({tr[a+4].rv, tr[a+4].re, tr[a+4].rt}), 80'({1'b1, 1'b1, 1'b0}));
    chk("t4_reissue", 80'({tr[a+4].ht, tr[a+4].ad}), 80'({2'b10, 10'h023}));
    chk("t4_rd_ok", 80'({tr[a+6].rv, tr[a+6].re}), 80'({1'b1, 1'b0}));

    // timeout with a write in D and a read in A
    start_trace();
    pw_q.push_back(1000); pe_q.push_back(1'b0);
    issue(1'b1, 10'h000, 2'b11, 64'hA5);
    issue(1'b0, 10'h018, 2'b11, 64'd0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h008; cmd_size = 2'b11; cmd_wdata = 64'h77;
    wait_cycles(16);
    a = acc_idx(0);
    chk("t5_no_early", 80'({tr[a+9].rv, tr[a+9].flt}), 80'(0));
    chk("t5_rsp_d", 80'({tr[a+10].rv, tr[a+10].re, tr[a+10].rt, tr[a+10].flt}), 80'(4'b1111));
    chk("t5_rsp_a", 80'({tr[a+11].rv, tr[a+11].re, tr[a+11].rt}), 80'(3'b111));
    for (int i = 10; i <= 16; i++) chk("t5_halt_ready", 80'(tr[a+i].cr), 80'(0));
    clr_fault = 1'b1;
    align();
    clr_fault = 1'b0;
    issue(1'b1, 10'h008, 2'b11, 64'h77);
    cmd_valid = 1'b0;
    wait_cycles(6);
    c = acc_idx(2);
    chk("t5_after_clr", 80'({tr[c+3].rv, tr[c+3].re, tr[c+3].flt}), 80'({1'b1, 1'b0, 1'b0}));

    // asynchronous reset during a data phase
    start_trace();
    pw_q.push_back(3); pe_q.push_back(1'b0);
    issue(1'b0, 10'h018, 2'b11, 64'd0);
    cmd_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_outputs_chk("mid_reset");
    clear_model();
    @(posedge clk);
    #2 rst = 1'b0;
    align();
    issue(1'b1, 10'h010, 2'b11, 64'h99);
    cmd_valid = 1'b0;
    wait_cycles(6);
    c = acc_idx(1);
    n_rv = 0;
    for (int i = 0; i < c; i++) n_rv += tr[i].rv;
    chk("t6_no_rsp_inflight", 80'(n_rv), 80'(0));
    chk("t6_first_after_rst", 80'({tr[c+3].rv, tr[c+3].re}), 80'({1'b1, 1'b0}));
    trace_on = 1'b0;

    // randomized traffic
    rand_sub = 1'b1;
    last_acc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!cmd_valid || last_acc) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_write = $urandom_range(0, 1);
        cmd_addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : regmap[$urandom_range(0, 7)];
        cmd_size  = $urandom_range(0, 3);
        cmd_wdata = {$urandom, $urandom};
      end
      clr_fault = m_fault && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      last_acc = cmd_valid && cmd_ready;
      align();
    end

    // drain
    rand_sub = 1'b0;
    cmd_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      clr_fault = m_fault;
      if (!m_fault && !dv && issue_q.size() == 0 && exp_q.size() == 0) break;
      align();
    end
    clr_fault = 1'b0;
    wait_cycles(2);
    chk("drain_empty", 80'({exp_q.size() == 0, issue_q.size() == 0, dv, m_fault}), 80'(4'b1100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_mgr.md
Name: ahb_mgr

Overview:
- AHB-Lite manager (initiator) that drives the accelerator's AHB subordinate register map: weight push 0x000, input push 0x008, bias 0x010, output 0x018, error 0x020, control 0x022, status 0x023, activation 0x024.
- Accepts single-transfer commands on a valid/ready interface and issues them as pipelined NONSEQ SINGLE transfers, overlapping each address phase with the previous data phase.
- Handles wait states and the two-cycle ERROR response, and guards against a hung subordinate with a timeout.
- Returns one response per command, in command order.

Parameters:
- TIMEOUT, 64: consecutive hready=0 data-phase cycles before the block declares a fault (minimum 2).
- ADDR_W, 10: haddr width.
- DATA_W, 64: data bus width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on an edge where cmd_valid&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_size  in  2  hsize value.
- cmd_wdata  in  DATA_W  write data, passed unmodified to hwdata.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  hrdata captured for reads; 0 for writes.
- rsp_err  out  1  transfer ended in ERROR or timeout.
- rsp_timeout  out  1  response caused by timeout.
- busy  out  1  address or data phase occupied.
- fault  out  1  timeout occurred; block halted.
- clr_fault  in  1  leaves HALT.
- hsel  out  1  high whenever htrans=NONSEQ.
- haddr  out  ADDR_W  address.
- htrans  out  2  IDLE=00 or NONSEQ=10 only.
- hsize  out  2  size.
- hburst  out  3  constant 000 (SINGLE).
- hwrite  out  1  direction.
- hwdata  out  DATA_W  data-phase write data.
- hready  in  1  subordinate ready.
- hresp  in  1  subordinate error.
- hrdata  in  DATA_W  read data.

Behaviour:
- Reset values: every output 0, except cmd_ready which is combinational. htrans=IDLE, hburst=000, fault=0, FSM=RUN, A and D empty.
- A register holds the address-phase command: valid, write, addr, size, wdata. D register holds the data-phase command: valid, write, wdata.
- Address outputs are driven from A. htrans=NONSEQ iff A.valid and not cancel. hwdata is driven from D.wdata.
- cancel = D.valid & hresp (combinational).
- RUN state:
  - cmd_ready = hready & ~cancel & (~A.valid | hready); net effect: cmd_ready = hready & ~cancel.
  - On an edge with hready=1 and ~cancel: D<=A, and A<=the command if accepted, else A.valid<=0.
  - While hready=0: A and D hold; address and data outputs stay stable.
- Completion: an edge with D.valid & hready=1 completes D.
  - Next cycle: rsp_valid=1, rsp_err=hresp, rsp_rdata=(~D.write ? hrdata : 0), rsp_timeout=0.
  - Latency with zero waits: accept edge E0, address phase E0..E1, data phase E1..E2, rsp_valid in the cycle after E2.
- ERROR response:
  - In both error cycles (hresp=1, hready=0, then hresp=1, hready=1), htrans is forced to IDLE and A is not transferred.
  - The second cycle completes D with rsp_err=1 and D.valid<=0.
  - A is re-issued as NONSEQ in the following cycle. Errors are not retried; the cancelled successor is.
- Timeout counter:
  - Increments each edge with D.valid & ~hready.
  - Clears on hready=1 or D empty.
  - When it reaches TIMEOUT-1 with hready still 0:
    - D completes with rsp_err=1 and rsp_timeout=1.
    - FSM goes to FLUSH.
    - fault<=1.
- FLUSH state (one cycle):
  - If A.valid, emit a second response (err=1, timeout=1) and clear A.
  - Go to HALT.
- HALT state:
  - htrans=IDLE, cmd_ready=0, fault=1.
  - clr_fault=1 returns the FSM to RUN and clears fault and the counter.
- busy = A.valid | D.valid.
- Simultaneous events:
  - A completion and a new acceptance on the same edge are both honoured.
  - clr_fault is ignored outside HALT.
- Reset mid-transfer: everything returns to reset values immediately. No response is issued for in-flight commands.

Test Plan:
- Write 0x010, wdata 0x1122334455667788, hready=1 → htrans=10, haddr=0x010, hwrite=1 one cycle after accept; hwdata=0x1122334455667788 next cycle; rsp_valid=1, rsp_err=0 three cycles after accept.
- Four back-to-back writes to 0x000 (wdata 1..4), cmd_valid held → htrans=NONSEQ for 4 consecutive cycles; hwdata=1,2,3,4 on consecutive cycles; 4 rsp pulses in order.
- Read 0x018 with hready=0 for 2 data-phase cycles, hrdata=0xDEADBEEFCAFEF00D → haddr, hwdata and htrans stable during waits; rsp_rdata=0xDEADBEEFCAFEF00D two cycles later than the zero-wait case.
- Write 0x030 followed by queued read 0x023; subordinate drives (hresp=1, hready=0) then (hresp=1, hready=1) → htrans=IDLE both cycles; rsp_err=1 for the write; read issued as NONSEQ next cycle; read rsp_err=0.
- TIMEOUT=8, hready held 0 with a write in D and a read in A → 8 cycles later two responses with rsp_err=1 and rsp_timeout=1; fault=1; cmd_ready=0 until a clr_fault pulse; then a new write completes normally.
- Assert rst during a data phase → all outputs 0 asynchronously; no rsp_valid; the first command after release completes with standard latency.
